// File: rtl/banked_sram_pm.sv
// rtl/banked_sram_pm.sv - multi-bank OBI SRAM with per-bank power-gate sequencing
//
// Purpose:
//   NUM_BANKS independent SRAM banks, each behind its own OBI slave port.
//   Each bank has a power-management FSM (ON/DRAIN/OFF/WAKE) that drains
//   outstanding read responses before gating and waits WAKE_CYCLES after
//   ungating before it grants again. The SRAM macro is modelled inline per
//   bank (behavioural array, byte-enable writes, registered read data).
//
// Ports:
//   clk_i            - clock
//   rst_ni           - asynchronous active-low reset
//   ram_req_i        - per-bank OBI request (req, we, addr, wdata, be)
//   ram_resp_o       - per-bank OBI response (gnt, rvalid, rdata)
//   pwrgate_ni       - per-bank power-gate request, 0 = request off
//   pwrgate_ack_no   - per-bank acknowledge, 0 = bank fully gated (OFF)
//   set_retentive_ni - per-bank retention control, 0 = retain while gated

package banked_sram_pm_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module banked_sram_pm
    import banked_sram_pm_pkg::*;
#(
    parameter int NUM_BANKS   = 2,
    parameter int BANK_BYTES  = 32768,
    parameter int RD_LATENCY  = 1,
    parameter int WAKE_CYCLES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  obi_req_t             ram_req_i [NUM_BANKS],
    output obi_resp_t            ram_resp_o [NUM_BANKS],
    input  logic [NUM_BANKS-1:0] pwrgate_ni,
    output logic [NUM_BANKS-1:0] pwrgate_ack_no,
    input  logic [NUM_BANKS-1:0] set_retentive_ni
);

    localparam int WORDS = BANK_BYTES / 4;
    localparam int IDX_W = $clog2(BANK_BYTES) - 2;

    typedef enum logic [1:0] {
        ST_ON    = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OFF   = 2'd2,
        ST_WAKE  = 2'd3
    } pm_state_e;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        pm_state_e        r_state;
        logic [7:0]       r_wake_cnt;
        logic             r_gnt_en;      // 1 only in ON
        logic             r_ack_n;       // 0 only in OFF
        logic             w_gnt;
        logic             w_macro_req;
        logic             w_macro_pwrgate_n;
        logic             w_macro_retentive_n;
        logic [IDX_W-1:0] w_idx;
        logic [31:0]      w_unused_addr;
        logic             w_pipe_busy;
        logic             w_rvalid;
        logic [31:0]      w_rdata;
        logic             r_rvalid1;
        logic [31:0]      r_macro_rdata;
        logic [31:0]      r_mem [WORDS];
        logic [WORDS-1:0] r_word_valid;

        // Crossbar has already decoded the bank; only the word index matters.
        assign w_idx         = ram_req_i[b].addr[IDX_W+1:2];
        assign w_unused_addr = ram_req_i[b].addr;

        assign w_gnt               = ram_req_i[b].req & r_gnt_en;
        assign w_macro_req         = ram_req_i[b].req & w_gnt;
        assign w_macro_pwrgate_n   = r_ack_n;
        assign w_macro_retentive_n = set_retentive_ni[b];

        assign pwrgate_ack_no[b] = r_ack_n;

        // Power-management FSM. gnt enable and ack are registered alongside
        // the state so they change exactly on state entry.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_state    <= ST_ON;
                r_wake_cnt <= 8'd0;
                r_gnt_en   <= 1'b1;
                r_ack_n    <= 1'b1;
            end else begin
                case (r_state)
                    ST_ON: begin
                        if (!pwrgate_ni[b]) begin
                            r_state  <= ST_DRAIN;
                            r_gnt_en <= 1'b0;
                        end
                    end
                    ST_DRAIN: begin
                        // A restored request wins over a completed drain.
                        if (pwrgate_ni[b]) begin
                            r_state  <= ST_ON;
                            r_gnt_en <= 1'b1;
                        end else if (!w_pipe_busy) begin
                            r_state <= ST_OFF;
                            r_ack_n <= 1'b0;
                        end
                    end
                    ST_OFF: begin
                        if (pwrgate_ni[b]) begin
                            r_state    <= ST_WAKE;
                            r_wake_cnt <= 8'(WAKE_CYCLES - 1);
                            r_ack_n    <= 1'b1;
                        end
                    end
                    ST_WAKE: begin
                        // Not abortable: a falling pwrgate_ni is only seen in ON.
                        if (r_wake_cnt == 8'd0) begin
                            r_state  <= ST_ON;
                            r_gnt_en <= 1'b1;
                        end else begin
                            r_wake_cnt <= r_wake_cnt - 8'd1;
                        end
                    end
                    default: begin
                        r_state  <= ST_ON;
                        r_gnt_en <= 1'b1;
                        r_ack_n  <= 1'b1;
                    end
                endcase
            end
        end

        // Macro storage. A non-retentive gate invalidates every word; an
        // invalid word reads back as zero until rewritten.
        always_ff @(posedge clk_i) begin
            if (!w_macro_pwrgate_n && w_macro_retentive_n) begin
                r_word_valid <= '0;
            end else if (w_macro_req && ram_req_i[b].we) begin
                for (int i = 0; i < 4; i++) begin
                    if (ram_req_i[b].be[i]) begin
                        r_mem[w_idx][8*i +: 8] <= ram_req_i[b].wdata[8*i +: 8];
                    end
                end
                r_word_valid[w_idx] <= 1'b1;
            end
        end

        // Macro read port and first response stage; writes also respond.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_rvalid1     <= 1'b0;
                r_macro_rdata <= 32'd0;
            end else begin
                r_rvalid1 <= w_macro_req;
                if (w_macro_req && !ram_req_i[b].we) begin
                    r_macro_rdata <= r_word_valid[w_idx] ? r_mem[w_idx] : 32'd0;
                end
            end
        end

        if (RD_LATENCY == 2) begin : g_lat2
            logic        r_rvalid2;
            logic [31:0] r_rdata2;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_rvalid2 <= 1'b0;
                    r_rdata2  <= 32'd0;
                end else begin
                    r_rvalid2 <= r_rvalid1;
                    r_rdata2  <= r_macro_rdata;
                end
            end

            assign w_rvalid    = r_rvalid2;
            assign w_rdata     = r_rdata2;
            assign w_pipe_busy = r_rvalid1 | r_rvalid2;
        end else begin : g_lat1
            assign w_rvalid    = r_rvalid1;
            assign w_rdata     = r_macro_rdata;
            assign w_pipe_busy = r_rvalid1;
        end

        assign ram_resp_o[b] = '{gnt: w_gnt, rvalid: w_rvalid, rdata: w_rdata};
    end

endmodule
